// File: rtl/iir_decim_avg.sv
// Boxcar-averaging decimator behind the first-order IIR filter, with a small FWFT result FIFO.
// Optional macro ROUND_EN selects round-half-up with clipping instead of floor truncation.
module iir_decim_avg #(
    parameter int W          = 16,
    parameter int DECIM_LOG2 = 2,
    parameter int FIFO_AW    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic signed [W-1:0] in_data,
    input  logic                clr_ovf,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_data,
    output logic [FIFO_AW:0]    fifo_count,
    output logic                overflow
);

`ifdef ROUND_EN
    // One guard bit so the rounding offset cannot wrap a full-scale sum.
    localparam int AW = W + DECIM_LOG2 + 1;
`else
    localparam int AW = W + DECIM_LOG2;
`endif
    localparam int                    DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]      FULL_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [DECIM_LOG2-1:0] LAST_PH  = '1;

`ifdef ROUND_EN
    localparam logic signed [AW-1:0] RND  = AW'(1) << (DECIM_LOG2 - 1);
    localparam logic signed [AW-1:0] MAXV = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

    function automatic logic signed [W-1:0] scale_result(input logic signed [AW-1:0] s);
        logic signed [AW-1:0] r;
        r = (s + RND) >>> DECIM_LOG2;
        if (r > MAXV)
            return MAXV[W-1:0];
        else if (r < MINV)
            return MINV[W-1:0];
        return r[W-1:0];
    endfunction
`else
    // Taking the upper W bits is an arithmetic shift, i.e. floor toward -inf.
    function automatic logic signed [W-1:0] scale_result(input logic signed [AW-1:0] s);
        return s[AW-1:DECIM_LOG2];
    endfunction
`endif

    logic signed [AW-1:0]    acc_p0;
    logic signed [AW-1:0]    samp_ext_p0;
    logic signed [AW-1:0]    sum_p0;
    logic [DECIM_LOG2-1:0]   phase_p0;
    logic                    vld_p0;
    logic signed [W-1:0]     res_p0;

    logic signed [W-1:0]     mem_p1 [DEPTH];
    logic signed [W-1:0]     last_p1;
    logic [FIFO_AW-1:0]      wr_ptr;
    logic [FIFO_AW-1:0]      rd_ptr;
    logic                    pop;
    logic                    full;
    logic                    wr_en;
    logic                    drop;

    // ---- stage p0: accumulate, detect end of block ----
    assign samp_ext_p0 = {{(AW-W){in_data[W-1]}}, in_data};
    assign sum_p0      = acc_p0 + samp_ext_p0;
    assign vld_p0      = in_valid && (phase_p0 == LAST_PH);
    assign res_p0      = scale_result(sum_p0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_p0   <= '0;
            phase_p0 <= '0;
        end else if (in_valid) begin
            phase_p0 <= phase_p0 + 1'b1;
            if (vld_p0)
                acc_p0 <= '0;
            else
                acc_p0 <= sum_p0;
        end
    end

    // ---- stage p1: result FIFO ----
    assign out_valid = (fifo_count != '0);
    assign full      = (fifo_count == FULL_CNT);
    assign pop       = out_valid && out_ready;
    // A pop on a full FIFO frees the slot for a simultaneous push.
    assign wr_en     = vld_p0 && (!full || pop);
    assign drop      = vld_p0 && full && !pop;
    assign out_data  = out_valid ? mem_p1[rd_ptr] : last_p1;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem_p1[wr_ptr] <= res_p0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            last_p1    <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                last_p1 <= mem_p1[rd_ptr];
            end
            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (drop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

endmodule
